// File: rtl/ysyx_rnu_maptable_if.sv
// rnu_fl_if: connection between the rename map unit and the free list.
//   alloc_req   map -> fl   take one physical register this cycle
//   alloc_pr    fl  -> map  physical register offered for allocation
//   alloc_empty fl  -> map  no physical register is available
//   dealloc_req map -> fl   return one physical register this cycle
//   dealloc_pr  map -> fl   physical register being returned
//   flush_pipe  map -> fl   pipeline flush
//   flush_rd    map -> fl   architectural destination committing in the flush cycle (0 if none)
interface rnu_fl_if #(
  parameter int RLEN = 5,
  parameter int PLEN = 6
);
  logic            alloc_req;
  logic [PLEN-1:0] alloc_pr;
  logic            alloc_empty;
  logic            dealloc_req;
  logic [PLEN-1:0] dealloc_pr;
  logic            flush_pipe;
  logic [RLEN-1:0] flush_rd;

  modport master (
    output alloc_req,
    input  alloc_pr,
    input  alloc_empty,
    output dealloc_req,
    output dealloc_pr,
    output flush_pipe,
    output flush_rd
  );

  modport slave (
    input  alloc_req,
    output alloc_pr,
    output alloc_empty,
    input  dealloc_req,
    input  dealloc_pr,
    input  flush_pipe,
    input  flush_rd
  );
endinterface

// File: rtl/ysyx_rnu_maptable.sv
// ysyx_rnu_maptable: register-rename map unit for a single-issue rename stage.
// Holds the speculative map, the committed map and per-physical-register busy bits.
// Ports:
//   clock, reset                       clock and synchronous active-high reset
//   in_valid / in_ready                rename handshake
//   in_rs1, in_rs2, in_rd              architectural sources / destination
//   out_prs1, out_prs2                 physical sources (combinational lookup)
//   out_rs1_ready, out_rs2_ready       source availability, with same-cycle wakeup bypass
//   out_prd, out_old_prd               new and previous physical destination
//   wb_valid, wb_prd                   writeback wakeup
//   commit_valid, commit_rd, commit_prd  retirement of one instruction
//   flush_pipe                         restore speculative map from committed map
//   fl                                 free-list port
module ysyx_rnu_maptable #(
  parameter int RNUM = 32,
  parameter int PNUM = 64,
  parameter int RLEN = 5,
  parameter int PLEN = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RLEN-1:0] in_rs1,
  input  logic [RLEN-1:0] in_rs2,
  input  logic [RLEN-1:0] in_rd,
  output logic [PLEN-1:0] out_prs1,
  output logic [PLEN-1:0] out_prs2,
  output logic            out_rs1_ready,
  output logic            out_rs2_ready,
  output logic [PLEN-1:0] out_prd,
  output logic [PLEN-1:0] out_old_prd,
  input  logic            wb_valid,
  input  logic [PLEN-1:0] wb_prd,
  input  logic            commit_valid,
  input  logic [RLEN-1:0] commit_rd,
  input  logic [PLEN-1:0] commit_prd,
  input  logic            flush_pipe,
  rnu_fl_if.master        fl
);

  logic [PLEN-1:0] spec_map_r [RNUM];
  logic [PLEN-1:0] cmt_map_r  [RNUM];
  logic [PNUM-1:0] busy_r;

  logic rd_nz_s;
  logic fire_s;
  logic alloc_en_s;
  logic commit_en_s;

  assign rd_nz_s     = (in_rd != {RLEN{1'b0}});
  assign commit_en_s = commit_valid && (commit_rd != {RLEN{1'b0}});

  // Handshake and free-list request/return; alloc/dealloc are suppressed on a reset edge.
  always_comb begin
    in_ready       = 1'b0;
    fire_s         = 1'b0;
    alloc_en_s     = 1'b0;
    fl.alloc_req   = 1'b0;
    fl.dealloc_req = 1'b0;
    fl.dealloc_pr  = {PLEN{1'b0}};
    fl.flush_pipe  = flush_pipe;
    fl.flush_rd    = {RLEN{1'b0}};
    in_ready       = !flush_pipe && !(rd_nz_s && fl.alloc_empty);
    fire_s         = in_valid && in_ready;
    alloc_en_s     = fire_s && rd_nz_s;
    if (reset) begin
      fl.alloc_req   = 1'b0;
      fl.dealloc_req = 1'b0;
    end else begin
      fl.alloc_req   = alloc_en_s;
      fl.dealloc_req = commit_en_s;
    end
    if (commit_en_s) begin
      fl.dealloc_pr = cmt_map_r[commit_rd];
    end else begin
      fl.dealloc_pr = {PLEN{1'b0}};
    end
    if (commit_valid) begin
      fl.flush_rd = commit_rd;
    end else begin
      fl.flush_rd = {RLEN{1'b0}};
    end
  end

  // Combinational map lookup, wakeup bypass and destination selection.
  always_comb begin
    out_prs1      = spec_map_r[in_rs1];
    out_prs2      = spec_map_r[in_rs2];
    out_old_prd   = spec_map_r[in_rd];
    out_rs1_ready = !busy_r[out_prs1] || (wb_valid && (wb_prd == out_prs1));
    out_rs2_ready = !busy_r[out_prs2] || (wb_valid && (wb_prd == out_prs2));
    if (rd_nz_s) begin
      out_prd = fl.alloc_pr;
    end else begin
      out_prd = {PLEN{1'b0}};
    end
  end

  // Speculative map: identity on reset, restored from committed map (with the
  // same-cycle commit merged) on flush, updated by a firing rename otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < RNUM; i++) begin
        spec_map_r[i] <= PLEN'(i);
      end
    end else if (flush_pipe) begin
      for (int i = 0; i < RNUM; i++) begin
        if (commit_en_s && (commit_rd == RLEN'(i))) begin
          spec_map_r[i] <= commit_prd;
        end else begin
          spec_map_r[i] <= cmt_map_r[i];
        end
      end
    end else if (alloc_en_s) begin
      spec_map_r[in_rd] <= fl.alloc_pr;
    end
  end

  // Committed map: identity on reset, updated by every non-x0 commit, flush or not.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < RNUM; i++) begin
        cmt_map_r[i] <= PLEN'(i);
      end
    end else if (commit_en_s) begin
      cmt_map_r[commit_rd] <= commit_prd;
    end
  end

  // Busy bits: cleared on reset/flush; writeback clears, allocation sets (set wins).
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_r <= {PNUM{1'b0}};
    end else if (flush_pipe) begin
      busy_r <= {PNUM{1'b0}};
    end else begin
      for (int i = 0; i < PNUM; i++) begin
        if (alloc_en_s && (fl.alloc_pr == PLEN'(i))) begin
          busy_r[i] <= 1'b1;
        end else if (wb_valid && (wb_prd == PLEN'(i))) begin
          busy_r[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_rnu_maptable.sv
module tb_ysyx_rnu_maptable;
  localparam int RLEN = 5;
  localparam int PLEN = 6;

  logic            clock = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [RLEN-1:0] in_rs1, in_rs2, in_rd;
  logic [PLEN-1:0] out_prs1, out_prs2, out_prd, out_old_prd;
  logic            out_rs1_ready, out_rs2_ready;
  logic            wb_valid;
  logic [PLEN-1:0] wb_prd;
  logic            commit_valid;
  logic [RLEN-1:0] commit_rd;
  logic [PLEN-1:0] commit_prd;
  logic            flush_pipe;

  int errors = 0;
  int checks = 0;

  rnu_fl_if #(.RLEN(RLEN), .PLEN(PLEN)) fl_if ();

  ysyx_rnu_maptable dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .out_prs1(out_prs1), .out_prs2(out_prs2),
    .out_rs1_ready(out_rs1_ready), .out_rs2_ready(out_rs2_ready),
    .out_prd(out_prd), .out_old_prd(out_old_prd),
    .wb_valid(wb_valid), .wb_prd(wb_prd),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_prd(commit_prd),
    .flush_pipe(flush_pipe),
    .fl(fl_if)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge, then return inputs to idle.
  task automatic tick();
    @(posedge clock);
    #1;
    in_valid = 1'b0; wb_valid = 1'b0; commit_valid = 1'b0; flush_pipe = 1'b0;
    in_rd = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    wb_valid = 1'b0; wb_prd = '0; commit_valid = 1'b0; commit_rd = '0;
    commit_prd = '0; flush_pipe = 1'b0;
    fl_if.alloc_pr = 6'd32; fl_if.alloc_empty = 1'b0;
    @(posedge clock); #1;
    do_reset();

    // Reset state
    in_rs1 = 5'd7; #1;
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_alloc_req", fl_if.alloc_req, 0);
    check_val("rst_dealloc_req", fl_if.dealloc_req, 0);
    check_val("rst_fl_flush", fl_if.flush_pipe, 0);
    check_val("rst_prs1", out_prs1, 7);
    check_val("rst_rdy1", out_rs1_ready, 1);

    // Basic rename
    in_valid = 1'b1; in_rs1 = 5'd3; in_rs2 = 5'd5; in_rd = 5'd7; #1;
    check_val("ren_prs1", out_prs1, 3);
    check_val("ren_prs2", out_prs2, 5);
    check_val("ren_rdy1", out_rs1_ready, 1);
    check_val("ren_rdy2", out_rs2_ready, 1);
    check_val("ren_prd", out_prd, 32);
    check_val("ren_old_prd", out_old_prd, 7);
    check_val("ren_alloc_req", fl_if.alloc_req, 1);
    tick();
    in_rs1 = 5'd7; #1;
    check_val("dep_prs1", out_prs1, 32);
    check_val("dep_rdy1", out_rs1_ready, 0);

    // rd=0 and empty free list
    fl_if.alloc_empty = 1'b1;
    in_valid = 1'b1; in_rs1 = 5'd0; in_rd = 5'd0; #1;
    check_val("x0_prd", out_prd, 0);
    check_val("x0_alloc_req", fl_if.alloc_req, 0);
    check_val("x0_in_ready", in_ready, 1);
    check_val("x0_prs1", out_prs1, 0);
    in_rd = 5'd4; fl_if.alloc_pr = 6'd33; #1;
    check_val("empty_in_ready", in_ready, 0);
    check_val("empty_alloc_req", fl_if.alloc_req, 0);
    tick();
    fl_if.alloc_empty = 1'b0;
    in_rs1 = 5'd4; #1;
    check_val("empty_map_kept", out_prs1, 4);

    // Wakeup bypass
    in_rs1 = 5'd7; wb_valid = 1'b1; wb_prd = 6'd32; #1;
    check_val("wb_bypass_rdy", out_rs1_ready, 1);
    tick();
    #1;
    check_val("wb_after_rdy", out_rs1_ready, 1);

    // Commit dealloc
    commit_valid = 1'b1; commit_rd = 5'd7; commit_prd = 6'd32; #1;
    check_val("cmt1_dealloc_req", fl_if.dealloc_req, 1);
    check_val("cmt1_dealloc_pr", fl_if.dealloc_pr, 7);
    tick();
    commit_valid = 1'b1; commit_rd = 5'd7; commit_prd = 6'd40; #1;
    check_val("cmt2_dealloc_pr", fl_if.dealloc_pr, 32);
    tick();
    commit_valid = 1'b1; commit_rd = 5'd0; commit_prd = 6'd9; #1;
    check_val("cmt_x0_dealloc_req", fl_if.dealloc_req, 0);
    tick();

    // Rename and commit to the same register in one cycle
    do_reset();
    in_valid = 1'b1; in_rd = 5'd5; fl_if.alloc_pr = 6'd36;
    commit_valid = 1'b1; commit_rd = 5'd5; commit_prd = 6'd37; #1;
    check_val("same_dealloc_pr", fl_if.dealloc_pr, 5);
    tick();
    in_rs1 = 5'd5; commit_valid = 1'b1; commit_rd = 5'd5; commit_prd = 6'd38; #1;
    check_val("same_spec", out_prs1, 36);
    check_val("same_cmt", fl_if.dealloc_pr, 37);
    tick();

    // Flush with same-cycle commit
    do_reset();
    in_valid = 1'b1; in_rd = 5'd7; fl_if.alloc_pr = 6'd32; tick();
    in_valid = 1'b1; in_rd = 5'd8; fl_if.alloc_pr = 6'd33; tick();
    in_valid = 1'b1; in_rd = 5'd9; fl_if.alloc_pr = 6'd34;
    commit_valid = 1'b1; commit_rd = 5'd7; commit_prd = 6'd32; flush_pipe = 1'b1; #1;
    check_val("fl_flush_rd", fl_if.flush_rd, 7);
    check_val("fl_flush_pipe", fl_if.flush_pipe, 1);
    check_val("fl_in_ready", in_ready, 0);
    check_val("fl_alloc_req", fl_if.alloc_req, 0);
    check_val("fl_dealloc_pr", fl_if.dealloc_pr, 7);
    tick();
    in_rs1 = 5'd7; in_rs2 = 5'd8; in_rd = 5'd9; #1;
    check_val("post_fl_prs1", out_prs1, 32);
    check_val("post_fl_prs2", out_prs2, 8);
    check_val("post_fl_rdy1", out_rs1_ready, 1);
    check_val("post_fl_rdy2", out_rs2_ready, 1);
    check_val("post_fl_in_ready", in_ready, 1);
    check_val("post_fl_old_prd", out_old_prd, 9);

    // Reset in the middle of renames
    in_valid = 1'b1; in_rd = 5'd7; fl_if.alloc_pr = 6'd35; tick();
    in_rs1 = 5'd7; #1;
    check_val("pre_rst_prs1", out_prs1, 35);
    reset = 1'b1; in_valid = 1'b1; in_rd = 5'd7; fl_if.alloc_pr = 6'd36;
    commit_valid = 1'b1; commit_rd = 5'd3; commit_prd = 6'd36; #1;
    check_val("midrst_alloc_req", fl_if.alloc_req, 0);
    check_val("midrst_dealloc_req", fl_if.dealloc_req, 0);
    tick();
    reset = 1'b0; in_rs1 = 5'd7; in_rs2 = 5'd3; #1;
    check_val("midrst_prs1", out_prs1, 7);
    check_val("midrst_rdy1", out_rs1_ready, 1);
    check_val("midrst_prs2", out_prs2, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ysyx_rnu_maptable.md
# ysyx_rnu_maptable

Register-rename map unit for the single-issue rename stage. It holds the speculative map table (architectural to physical register), the committed map table and the per-physical-register busy bits. It draws new physical registers from the free list and, at commit, returns the superseded physical register to the free list. On a pipeline flush it restores the speculative map from the committed map and drives the free list's flush inputs.

## Interface
Parameters:
- RNUM, `YSYX_REG_SIZE (32): number of architectural registers.
- PNUM, `YSYX_PHY_SIZE (64): number of physical registers.
- RLEN, `YSYX_REG_LEN (5): architectural index width.
- PLEN, `YSYX_PHY_LEN (6): physical index width.

Ports:
- clock  in  1  single clock; everything is sampled on posedge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  a rename request is present.
- in_ready  out  1  the request is accepted this cycle.
- in_rs1, in_rs2, in_rd  in  RLEN each  architectural sources and destination.
- out_prs1, out_prs2  out  PLEN each  physical sources, combinational.
- out_rs1_ready, out_rs2_ready  out  1 each  the source value is available.
- out_prd  out  PLEN  newly allocated destination; 0 when in_rd==0.
- out_old_prd  out  PLEN  previous speculative mapping of in_rd, carried to the ROB.
- wb_valid  in  1  writeback wakeup.
- wb_prd  in  PLEN  physical register written back.
- commit_valid  in  1  one instruction retires.
- commit_rd  in  RLEN  its architectural destination.
- commit_prd  in  PLEN  its physical destination.
- flush_pipe  in  1  misprediction or exception flush.
- fl  rnu_fl_if.master  free-list port: alloc_req, alloc_pr, alloc_empty, dealloc_req, dealloc_pr, flush_pipe, flush_rd.

## Operation
Reset:
- spec_map[i] = i and cmt_map[i] = i for i in 0..RNUM-1.
- busy[] all 0.
- Outputs with in_valid=0: in_ready=1, fl.alloc_req=0, fl.dealloc_req=0, fl.flush_pipe=0.

Rename:
- Lookup is combinational: out_prs1 = spec_map[in_rs1], out_prs2 = spec_map[in_rs2], out_old_prd = spec_map[in_rd].
- need_alloc = in_valid && in_rd != 0. fl.alloc_req = need_alloc && in_ready.
- in_ready = !flush_pipe && !(in_rd != 0 && fl.alloc_empty).
- out_prd = fl.alloc_pr when in_rd != 0, else 0.
- Fire is in_valid && in_ready. On fire with rd != 0:
  - spec_map[in_rd] <= fl.alloc_pr.
  - busy[fl.alloc_pr] <= 1.
- A request with rd == 0 never allocates. x0 stays mapped to p0, and p0 is never busy.

Readiness:
- out_rsN_ready = !busy[prsN] || (wb_valid && wb_prd == prsN). The same-cycle wakeup is bypassed.
- On wb_valid, busy[wb_prd] <= 0.
- If a set and a clear hit the same index in one cycle, the set wins. Legal traffic never produces this.

Commit:
- When commit_valid && commit_rd != 0:
  - fl.dealloc_req = 1 and fl.dealloc_pr = cmt_map[commit_rd], combinational.
  - cmt_map[commit_rd] <= commit_prd.
- When commit_rd == 0, there is no dealloc and no update.
- Commit proceeds even in a flush cycle.

Flush:
- fl.flush_pipe = flush_pipe.
- fl.flush_rd = (commit_valid ? commit_rd : 0). This is non-zero exactly when a dealloc happens in the flush cycle.
- spec_map <= cmt_map, with the same-cycle commit merged in, so spec_map[commit_rd] gets commit_prd.
- busy[] <= all 0.
- No rename fires during the flush cycle.

## Timing
- Rename: zero-latency lookup. The map update is visible the next cycle. Back-to-back dependent renames therefore see each other.
- Commit dealloc is presented in the same cycle as commit_valid. The free list writes it at that edge.
- Flush takes 1 cycle. The cycle after flush_pipe sees the restored map, and in_ready=1 if the free list is non-empty.
- Boundaries:
  - Free list empty: in_ready=0 for rd != 0. Requests with rd == 0 still fire.
  - Rename and commit to the same architectural register in one cycle: both tables update independently.
  - Reset asserted mid-operation: all state returns to reset values at that edge, with no dealloc and no alloc.

## Test plan
- After reset, rename rs1=3, rs2=5, rd=7: prs1=3, prs2=5, both ready=1, prd=32, old_prd=7, alloc_req=1. Next cycle, rename rs1=7: prs1=32, ready=0.
- Rename rd=0 with rs1=0: prd=0, alloc_req=0, in_ready=1 even with alloc_empty=1. With alloc_empty=1, rename rd=4: in_ready=0 and the map is unchanged.
- Rename x7→32, then wb_valid with wb_prd=32 in the same cycle as a lookup of rs1=7: ready=1. The next cycle, ready=1 without wb.
- commit_rd=7, commit_prd=32 after reset: dealloc_req=1, dealloc_pr=7. Then commit_rd=7, commit_prd=40: dealloc_pr=32.
- Rename x7→32 and x8→33, commit x7 (prd 32) in the same cycle as flush_pipe: fl.flush_rd=7, in_ready=0. Next cycle, rs1=7 gives 32 and rs1=8 gives 8, all ready=1.
- Assert reset during a run of renames: the next cycle, prs1 for rs1=7 is 7, ready=1, and no alloc or dealloc is seen at the reset edge.
